// File: rtl/rasterizer_pkg.sv
// Shared rasterizer types: set-up triangle, per-pixel work item, and traversal-stage types.
package rasterizer_pkg;

    localparam int unsigned COORD_W = 16;

    // Edge function a*x + b*y + c
    typedef struct packed {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [31:0] c;
    } edge_t;

    typedef struct packed {
        edge_t [2:0]        edges;
        logic signed [31:0] d00;
        logic signed [31:0] d01;
        logic signed [31:0] d11;
        logic [31:0]        denom_inv;
        logic [2:0][23:0]   colors;
        logic [2:0][15:0]   depths;
    } triangle_state_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        triangle_state_t           triangle;
    } pixel_state_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] min_x;
        logic signed [COORD_W-1:0] min_y;
        logic signed [COORD_W-1:0] max_x;
        logic signed [COORD_W-1:0] max_y;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WALK,
        DRAIN
    } trav_state_e;

endpackage

// File: rtl/pixel_traversal_ctrl_bbox_clamp.sv
// Clamps a raw inclusive bounding box to the screen and flags boxes that end up empty.
module bbox_clamp
    import rasterizer_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  bbox_t raw_box,
    output bbox_t clamped_box,
    output logic  empty
);

    localparam logic signed [COORD_W-1:0] MaxX = COORD_W'(WIDTH - 1);
    localparam logic signed [COORD_W-1:0] MaxY = COORD_W'(HEIGHT - 1);

    always_comb begin
        clamped_box = raw_box;
        if ($signed(raw_box.min_x) < $signed(16'sd0)) clamped_box.min_x = '0;
        if ($signed(raw_box.min_y) < $signed(16'sd0)) clamped_box.min_y = '0;
        if ($signed(raw_box.max_x) > MaxX)            clamped_box.max_x = MaxX;
        if ($signed(raw_box.max_y) > MaxY)            clamped_box.max_y = MaxY;
    end

    // Boxes wholly off-screen invert after clamping, so this one test covers them too
    assign empty = ($signed(clamped_box.min_x) > $signed(clamped_box.max_x)) ||
                   ($signed(clamped_box.min_y) > $signed(clamped_box.max_y));

endmodule

// File: rtl/pixel_traversal_ctrl.sv
// Walks a clamped triangle bounding box in raster order, feeding pixel_eval one pixel per
// handshake, and signals completion only once pixel_eval has drained.
module pixel_traversal_ctrl
    import rasterizer_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                      clk,
    input  logic                      rst,
    input  triangle_state_t           tri_in,
    input  logic signed [COORD_W-1:0] bbox_min_x,
    input  logic signed [COORD_W-1:0] bbox_min_y,
    input  logic signed [COORD_W-1:0] bbox_max_x,
    input  logic signed [COORD_W-1:0] bbox_max_y,
    input  logic                      tri_valid,
    output logic                      tri_ready,
    output pixel_state_t              pix_out,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    input  logic                      eval_busy,
    output logic                      tri_done,
    output logic                      busy,
    output logic [31:0]               pix_count
);

    trav_state_e               state_q, state_d;
    logic                      done_q, done_d;
    triangle_state_t           tri_q;
    bbox_t                     raw_q, box_q, clamped;
    logic                      box_empty;
    logic signed [COORD_W-1:0] cur_x_q, cur_y_q;
    logic [31:0]               pix_count_q;
    logic                      accept, handshake, row_end, last_pix;

    bbox_clamp #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_bbox_clamp (
        .raw_box    (raw_q),
        .clamped_box(clamped),
        .empty      (box_empty)
    );

    assign accept    = (state_q == IDLE) && tri_valid;
    assign handshake = (state_q == WALK) && pix_ready;
    assign row_end   = (cur_x_q == box_q.max_x);
    assign last_pix  = row_end && (cur_y_q == box_q.max_y);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (tri_valid) state_d = SETUP;
            SETUP: state_d = box_empty ? DRAIN : WALK;
            WALK:  if (pix_ready && last_pix) state_d = DRAIN;
            DRAIN: begin
                // Stay one extra DRAIN cycle so tri_done is registered and tri_ready stays low
                if (done_q) begin
                    state_d = IDLE;
                end else if (!eval_busy) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tri_q       <= '0;
            raw_q       <= '0;
            box_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pix_count_q <= '0;
        end else begin
            if (accept) begin
                tri_q <= tri_in;
                raw_q <= '{min_x: bbox_min_x, min_y: bbox_min_y,
                           max_x: bbox_max_x, max_y: bbox_max_y};
            end
            if (state_q == SETUP) begin
                box_q   <= clamped;
                cur_x_q <= clamped.min_x;
                cur_y_q <= clamped.min_y;
            end
            if (handshake) begin
                pix_count_q <= pix_count_q + 32'd1;
                if (row_end) begin
                    cur_x_q <= box_q.min_x;
                    cur_y_q <= cur_y_q + 16'sd1;
                end else begin
                    cur_x_q <= cur_x_q + 16'sd1;
                end
            end
        end
    end

    assign tri_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pix_valid = (state_q == WALK);
    assign tri_done  = done_q;
    assign pix_count = pix_count_q;
    assign pix_out   = {cur_x_q, cur_y_q, tri_q};

endmodule
